// File: rtl/bitwise_logic_pipe.sv
// Single-stage bitwise ALU with a valid/ready handshake on each side.
// The ACC_AND and ACC_OR ops fold operand a across a burst that ends on in_last.
module bitwise_logic_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [CNT_W-1:0] out_cnt
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [2:0] OP_AND     = 3'b000;
  localparam logic [2:0] OP_OR      = 3'b001;
  localparam logic [2:0] OP_XOR     = 3'b010;
  localparam logic [2:0] OP_NAND    = 3'b011;
  localparam logic [2:0] OP_NOR     = 3'b100;
  localparam logic [2:0] OP_ACC_AND = 3'b110;

  state_t           state_q, state_d;
  logic [2:0]       burst_op_q, burst_op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             out_valid_q, out_valid_d;

  logic             in_fire;
  logic             first;
  logic [2:0]       eff_op;
  logic [WIDTH-1:0] logic_res;
  logic [WIDTH-1:0] fold;
  logic [CNT_W-1:0] beats;

  assign in_ready = !out_valid_q || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign first    = (state_q == IDLE);
  // Once a burst is open the latched op wins, so a stray op cannot break it.
  assign eff_op   = first ? op : burst_op_q;

  always_comb begin
    logic_res = '0;
    case (eff_op)
      OP_AND:  logic_res = a & b;
      OP_OR:   logic_res = a | b;
      OP_XOR:  logic_res = a ^ b;
      OP_NAND: logic_res = ~(a & b);
      OP_NOR:  logic_res = ~(a | b);
      default: logic_res = ~(a ^ b);
    endcase
  end

  assign fold  = first ? a : (eff_op[0] ? (acc_q | a) : (acc_q & a));
  // Saturating beat count; the fold above still takes every beat.
  assign beats = first ? CNT_W'(1)
               : ((cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1));

  always_comb begin
    state_d     = state_q;
    burst_op_d  = burst_op_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_cnt_d   = out_cnt_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (in_fire) begin
      if (eff_op[2:1] == 2'b11) begin
        if (first) begin
          burst_op_d = op;
        end
        if (in_last) begin
          out_d       = fold;
          out_cnt_d   = beats;
          out_valid_d = 1'b1;
          acc_d       = '0;
          cnt_d       = '0;
          state_d     = IDLE;
        end else begin
          acc_d   = fold;
          cnt_d   = beats;
          state_d = ACCUM;
        end
      end else begin
        out_d       = logic_res;
        out_cnt_d   = CNT_W'(1);
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      burst_op_q  <= OP_ACC_AND;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_op_q  <= burst_op_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_cnt_q   <= out_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_cnt   = out_cnt_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Directed bench for bitwise_logic_pipe: a vector table of bitwise ops plus
// hand-written accumulate, stall, saturation and reset sequences.
module tb_bitwise_logic_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic [7:0] out_cnt;

  logic       in_ready2;
  logic       out_valid2;
  logic [7:0] out2;
  logic [1:0] out_cnt2;

  int total;
  int bad;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[9];

  bitwise_logic_pipe #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .out_cnt(out_cnt)
  );

  // Narrow-counter copy sharing the same stimulus, used for saturation.
  bitwise_logic_pipe #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .op(op), .a(a), .b(b), .in_last(in_last), .out_valid(out_valid2),
    .out_ready(out_ready), .out(out2), .out_cnt(out_cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv, input logic last);
    in_valid = 1'b1;
    op       = o;
    a        = av;
    b        = bv;
    in_last  = last;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    vecs[0] = '{3'b000, 8'hF0, 8'h3C, 8'h30};
    vecs[1] = '{3'b001, 8'hF0, 8'h3C, 8'hFC};
    vecs[2] = '{3'b010, 8'hF0, 8'h3C, 8'hCC};
    vecs[3] = '{3'b011, 8'hF0, 8'h3C, 8'hCF};
    vecs[4] = '{3'b100, 8'hF0, 8'h3C, 8'h03};
    vecs[5] = '{3'b101, 8'hF0, 8'h3C, 8'h33};
    vecs[6] = '{3'b101, 8'hAA, 8'h0F, 8'h5A};
    vecs[7] = '{3'b010, 8'h55, 8'hFF, 8'hAA};
    vecs[8] = '{3'b000, 8'hA5, 8'hFF, 8'hA5};

    rst_n = 1'b0; in_valid = 1'b0; op = 3'b000; a = '0; b = '0;
    in_last = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_out_cnt", out_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Back-to-back bitwise table, one result per cycle.
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      beat(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
      #1;
      chk($sformatf("vec%0d_in_ready", i), in_ready, 1);
      step();
      chk($sformatf("vec%0d_out", i), out, vecs[i].exp);
      chk($sformatf("vec%0d_cnt", i), out_cnt, 1);
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
    end

    // Back-to-back XOR stream.
    for (int i = 0; i < 4; i++) begin
      beat(3'b010, 8'(i * 8'h11), 8'h0F, 1'b1);
      #1;
      chk($sformatf("xor%0d_in_ready", i), in_ready, 1);
      step();
      chk($sformatf("xor%0d_out", i), out, 8'(i * 8'h11) ^ 8'h0F);
      chk($sformatf("xor%0d_valid", i), out_valid, 1);
    end

    // ACC_AND burst FF, 7E, 3C(last).
    beat(3'b110, 8'hFF, 8'h00, 1'b0);
    step();
    chk("accand_b1_valid", out_valid, 0);
    beat(3'b110, 8'h7E, 8'h55, 1'b0);
    step();
    chk("accand_b2_valid", out_valid, 0);
    beat(3'b110, 8'h3C, 8'h00, 1'b1);
    step();
    chk("accand_out", out, 8'h3C);
    chk("accand_cnt", out_cnt, 3);
    chk("accand_valid", out_valid, 1);
    in_valid = 1'b0;
    step();
    chk("accand_drain", out_valid, 0);

    // ACC_OR burst whose later beats carry other ops; the burst op must stick.
    beat(3'b111, 8'h01, 8'h00, 1'b0);
    step();
    beat(3'b000, 8'h02, 8'h00, 1'b0);
    step();
    chk("sticky_mid_valid", out_valid, 0);
    beat(3'b110, 8'h04, 8'h00, 1'b1);
    step();
    chk("sticky_out", out, 8'h07);
    chk("sticky_cnt", out_cnt, 3);
    in_valid = 1'b0;
    step();

    // XNOR result stalled downstream for 3 cycles, next beat held off.
    out_ready = 1'b0;
    beat(3'b101, 8'hAA, 8'h0F, 1'b0);
    step();
    chk("stall_first_out", out, 8'h5A);
    beat(3'b000, 8'hFF, 8'h0F, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall%0d_out", i), out, 8'h5A);
      chk($sformatf("stall%0d_cnt", i), out_cnt, 1);
      chk($sformatf("stall%0d_valid", i), out_valid, 1);
      chk($sformatf("stall%0d_in_ready", i), in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("unstall_in_ready", in_ready, 1);
    step();
    chk("unstall_out", out, 8'h0F);
    chk("unstall_valid", out_valid, 1);
    in_valid = 1'b0;
    step();
    chk("unstall_drain", out_valid, 0);

    // Five-beat ACC_OR burst; the CNT_W=2 copy saturates at 3.
    for (int i = 0; i < 5; i++) begin
      beat(3'b111, 8'(1 << i), 8'h00, i == 4);
      step();
      if (i < 4) chk($sformatf("sat_b%0d_valid", i), out_valid2, 0);
    end
    chk("sat_out", out2, 8'h1F);
    chk("sat_cnt", out_cnt2, 3);
    chk("sat_in_ready", in_ready2, 1);
    chk("wide_cnt", out_cnt, 5);
    chk("wide_out", out, 8'h1F);
    in_valid = 1'b0;
    step();

    // Reset in the middle of an ACC_AND burst.
    beat(3'b110, 8'hF0, 8'h00, 1'b0);
    step();
    beat(3'b110, 8'h33, 8'h00, 1'b0);
    step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("midrst_no_result", out_valid, 0);
    beat(3'b110, 8'h0F, 8'h00, 1'b1);
    step();
    chk("midrst_out", out, 8'h0F);
    chk("midrst_cnt", out_cnt, 1);
    chk("midrst_valid_after", out_valid, 1);
    in_valid = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bitwise_logic_pipe.md
BITWISE_LOGIC_PIPE -- requirements
Module: bitwise_logic_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, as the operand and result width in bits (legal range 1..64).
REQ-002 The block SHALL have parameter CNT_W, default 8, as the width of the burst beat counter.
REQ-003 The block SHALL have one clock, clk, an input of width 1; all state SHALL update on its rising edge.
REQ-004 The block SHALL have rst_n, an input of width 1, as an asynchronous, active-low reset.
REQ-005 The block SHALL have in_valid, an input of width 1, asserted when an operand beat is offered.
REQ-006 The block SHALL have in_ready, an output of width 1, asserted when the block can accept a beat.
REQ-007 The block SHALL have op, an input of width 3, as the operation select.
REQ-008 The block SHALL have a and b, each an input of width WIDTH, as the operands.
REQ-009 The block SHALL have in_last, an input of width 1, marking the final beat of an accumulate burst.
REQ-010 The block SHALL have out_valid, an output of width 1, asserted when the result is valid.
REQ-011 The block SHALL have out_ready, an input of width 1, asserted when downstream accepts the result.
REQ-012 The block SHALL have out, an output of width WIDTH, carrying the result.
REQ-013 The block SHALL have out_cnt, an output of width CNT_W, giving the number of beats folded into the result.

Function
REQ-014 Op encoding SHALL be: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 ACC_AND, 111 ACC_OR.
REQ-015 A beat SHALL transfer on an input edge with in_valid && in_ready; a result SHALL transfer on an output edge with out_valid && out_ready.
REQ-016 in_ready SHALL be combinational: !out_valid || out_ready.
REQ-017 Ops 000-101 SHALL be bitwise over WIDTH bits, on a accepted beat: out <= f(a,b), out_cnt <= 1, out_valid <= 1, latency exactly 1 cycle; in_last ignored.
REQ-018 ACC ops SHALL reduce a across a burst; b SHALL be ignored.
REQ-019 The first accepted ACC beat SHALL latch op into burst_op and load acc <= a; later beats SHALL use burst_op and ignore op until the burst ends.
REQ-020 Each non-last ACC beat SHALL update acc <= acc AND/OR a, increment the beat count, and leave out_valid unchanged.
REQ-021 The ACC beat with in_last=1 SHALL set out <= (first ? a : acc op a), out_cnt <= beats including this one, out_valid <= 1, and return to IDLE.
REQ-022 The state machine SHALL have two states: IDLE and ACCUM.
REQ-023 In IDLE, an ACC beat with in_last=0 SHALL go to ACCUM; a single-beat ACC burst with in_last=1 SHALL produce a result with out_cnt=1 and stay in IDLE.
REQ-024 ACCUM SHALL go to IDLE on the in_last beat.
REQ-025 In ACCUM, in_ready SHALL follow REQ-016 for every beat, including non-last beats.
REQ-026 The beat counter SHALL saturate at 2^CNT_W-1 and never wrap; the reduction SHALL still include every beat.
REQ-027 While out_valid=1 and out_ready=0, out, out_cnt and out_valid SHALL hold stable.
REQ-028 With simultaneous output accept and input accept, the new result SHALL replace the old with out_valid held at 1 (full throughput, no bubble).
REQ-029 A non-ACC op received in ACCUM SHALL be treated as burst_op, so a burst cannot be interrupted.

Reset
REQ-030 While rst_n=0, the block SHALL force out_valid=0, out=0, out_cnt=0, acc=0, beat count=0, state=IDLE and burst_op=ACC_AND, independent of clk.
REQ-031 Reset mid-burst SHALL discard the partial accumulation, with no result emitted after release.
REQ-032 in_ready SHALL be 1 during and immediately after reset, per REQ-016.

Verification
REQ-033 The bench SHALL apply op=000, a=0xF0, b=0x3C, out_ready=1 and require out=0x30, out_cnt=1, out_valid=1 one cycle later.
REQ-034 The bench SHALL apply ACC_AND beats a=0xFF, 0x7E, 0x3C (last) and require one result out=0x3C, out_cnt=3, with no out_valid before the last beat.
REQ-035 The bench SHALL apply op=101, a=0xAA, b=0x0F with out_ready=0 for 3 cycles and require out=0x5A held, in_ready=0, and the next beat stalled until out_ready=1.
REQ-036 The bench SHALL apply back-to-back XOR beats with out_ready=1 and require one result per cycle, in_ready constantly 1.
REQ-037 The bench SHALL apply CNT_W=2 with an ACC_OR burst of 5 beats, a=0x01,0x02,0x04,0x08,0x10, and require out=0x1F, out_cnt=3 (saturated).
REQ-038 The bench SHALL pulse rst_n low after 2 ACC_AND beats, then send a single ACC_AND beat a=0x0F with in_last=1, and require out=0x0F, out_cnt=1.
